// File: rtl/ram_initiator.sv
// ram_initiator: single-request initiator for a CE-strobed synchronous RAM.
// A request is latched onto the RAM pins on acceptance. CE rises after
// SETUP_CYC clocks, stays high for HOLD_CYC clocks, then falls. One
// recovery clock follows before returning to idle. Read data is captured
// from q on the edge that drops CE. Every output comes straight from a flop.
module ram_initiator #(
   parameter int ADDR_W    = 10,
   parameter int DATA_W    = 18,
   parameter int SETUP_CYC = 1,
   parameter int HOLD_CYC  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_we,
   output logic              mem_ce,
   input  logic [DATA_W-1:0] mem_q
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SETUP   = 2'd1;
   localparam logic [1:0] ST_STROBE  = 2'd2;
   localparam logic [1:0] ST_RECOVER = 2'd3;

   // The counter is loaded with N-1 so that a phase lasts exactly N clocks.
   localparam logic [7:0] SETUP_LOAD = 8'(SETUP_CYC - 1);
   localparam logic [7:0] HOLD_LOAD  = 8'(HOLD_CYC - 1);

   logic [1:0]        state_reg;
   logic [7:0]        count_reg;
   logic              req_ready_reg;
   logic              busy_reg;
   logic              rsp_valid_reg;
   logic [DATA_W-1:0] rsp_rdata_reg;
   logic [ADDR_W-1:0] mem_address_reg;
   logic [DATA_W-1:0] mem_data_reg;
   logic              mem_we_reg;
   logic              mem_ce_reg;

   logic accept;
   logic count_zero;

   // req_ready is only ever high in IDLE, so this also implies the IDLE state.
   assign accept     = req_valid && req_ready_reg;
   assign count_zero = (count_reg == 8'd0);

   // Sequencer: state, phase counter, handshake flags and the CE strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         count_reg     <= 8'd0;
         req_ready_reg <= 1'b0;
         busy_reg      <= 1'b0;
         mem_ce_reg    <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               mem_ce_reg <= 1'b0;
               if (accept) begin
                  state_reg     <= ST_SETUP;
                  count_reg     <= SETUP_LOAD;
                  req_ready_reg <= 1'b0;
                  busy_reg      <= 1'b1;
               end else begin
                  req_ready_reg <= 1'b1;
                  busy_reg      <= 1'b0;
               end
            end
            ST_SETUP: begin
               if (count_zero) begin
                  mem_ce_reg <= 1'b1;
                  count_reg  <= HOLD_LOAD;
                  state_reg  <= ST_STROBE;
               end else begin
                  count_reg <= count_reg - 8'd1;
               end
            end
            ST_STROBE: begin
               if (count_zero) begin
                  mem_ce_reg <= 1'b0;
                  state_reg  <= ST_RECOVER;
               end else begin
                  count_reg <= count_reg - 8'd1;
               end
            end
            ST_RECOVER: begin
               state_reg     <= ST_IDLE;
               req_ready_reg <= 1'b1;
               busy_reg      <= 1'b0;
            end
            default: begin
               state_reg     <= ST_IDLE;
               count_reg     <= 8'd0;
               req_ready_reg <= 1'b0;
               busy_reg      <= 1'b0;
               mem_ce_reg    <= 1'b0;
            end
         endcase
      end
   end

   // RAM address/data/WE: loaded only on the accept edge, held otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_address_reg <= '0;
         mem_data_reg    <= '0;
         mem_we_reg      <= 1'b0;
      end else if (accept) begin
         mem_address_reg <= req_addr;
         mem_data_reg    <= req_wdata;
         mem_we_reg      <= req_we;
      end
   end

   // Read response: capture q on the CE-falling edge, at least one clock after CE rose.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_reg <= 1'b0;
         rsp_rdata_reg <= '0;
      end else begin
         rsp_valid_reg <= 1'b0;
         if (state_reg == ST_STROBE && count_zero && !mem_we_reg) begin
            rsp_valid_reg <= 1'b1;
            rsp_rdata_reg <= mem_q;
         end
      end
   end

   assign req_ready   = req_ready_reg;
   assign busy        = busy_reg;
   assign rsp_valid   = rsp_valid_reg;
   assign rsp_rdata   = rsp_rdata_reg;
   assign mem_address = mem_address_reg;
   assign mem_data    = mem_data_reg;
   assign mem_we      = mem_we_reg;
   assign mem_ce      = mem_ce_reg;

endmodule

// File: tb/tb_ram_initiator.sv
// Bench for ram_initiator: two instances (default timing and stretched timing),
// each driving a behavioural CE-strobed RAM. Expectations come from a reference
// memory array and timing arithmetic on SETUP/HOLD.
module tb_ram_initiator;
   localparam int AW = 10;
   localparam int DW = 18;
   localparam int S0 = 1;
   localparam int H0 = 1;
   localparam int S1 = 3;
   localparam int H1 = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // shared request bus, steered to one instance by sel
   logic          req_valid = 1'b0;
   logic          req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          sel = 1'b0;
   logic          req_valid0, req_valid1;
   assign req_valid0 = req_valid & ~sel;
   assign req_valid1 = req_valid & sel;

   logic          req_ready0, rsp_valid0, busy0, mem_we0, mem_ce0;
   logic [DW-1:0] rsp_rdata0, mem_data0, mem_q0;
   logic [AW-1:0] mem_address0;
   logic          req_ready1, rsp_valid1, busy1, mem_we1, mem_ce1;
   logic [DW-1:0] rsp_rdata1, mem_data1, mem_q1;
   logic [AW-1:0] mem_address1;

   ram_initiator #(.ADDR_W(AW), .DATA_W(DW), .SETUP_CYC(S0), .HOLD_CYC(H0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .busy(busy0),
      .mem_address(mem_address0), .mem_data(mem_data0), .mem_we(mem_we0),
      .mem_ce(mem_ce0), .mem_q(mem_q0));

   ram_initiator #(.ADDR_W(AW), .DATA_W(DW), .SETUP_CYC(S1), .HOLD_CYC(H1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .busy(busy1),
      .mem_address(mem_address1), .mem_data(mem_data1), .mem_we(mem_we1),
      .mem_ce(mem_ce1), .mem_q(mem_q1));

   // behavioural RAMs: act on the rising edge of CE
   logic [DW-1:0] ram0 [0:1023];
   logic [DW-1:0] ram1 [0:1023];
   always @(posedge mem_ce0) if (mem_we0) ram0[mem_address0] <= mem_data0; else mem_q0 <= ram0[mem_address0];
   always @(posedge mem_ce1) if (mem_we1) ram1[mem_address1] <= mem_data1; else mem_q1 <= ram1[mem_address1];

   // reference contents of the default-timing RAM
   logic [DW-1:0] ref_mem [0:1023];

   // muxed view of the selected instance
   logic          m_ready, m_rsp, m_ce, m_we;
   logic [DW-1:0] m_rdata, m_data;
   logic [AW-1:0] m_addr;
   assign m_ready = sel ? req_ready1 : req_ready0;
   assign m_rsp   = sel ? rsp_valid1 : rsp_valid0;
   assign m_ce    = sel ? mem_ce1 : mem_ce0;
   assign m_we    = sel ? mem_we1 : mem_we0;
   assign m_rdata = sel ? rsp_rdata1 : rsp_rdata0;
   assign m_data  = sel ? mem_data1 : mem_data0;
   assign m_addr  = sel ? mem_address1 : mem_address0;

   // monitors: CE rising edges, response pulses, pin changes while CE high or falling
   int ce_edges0 = 0;
   int rsp_pulses0 = 0;
   int chg_viol = 0;
   logic prev_ce0 = 1'b0;
   logic prev_we0 = 1'b0;
   logic [AW-1:0] prev_addr0 = '0;
   always @(posedge mem_ce0) ce_edges0 <= ce_edges0 + 1;
   always @(negedge clk) begin
      if (rsp_valid0 === 1'b1) rsp_pulses0 <= rsp_pulses0 + 1;
      if (rst_n === 1'b1 && (mem_ce0 === 1'b1 || prev_ce0 === 1'b1) &&
          (mem_address0 !== prev_addr0 || mem_we0 !== prev_we0))
         chg_viol <= chg_viol + 1;
      prev_ce0   <= (rst_n === 1'b1) ? mem_ce0 : 1'b0;
      prev_addr0 <= mem_address0;
      prev_we0   <= mem_we0;
   end

   initial begin
      if (S0 < 1 || S0 > 255 || H0 < 1 || H0 > 255 || S1 < 1 || S1 > 255 || H1 < 1 || H1 > 255) begin
         $display("FAIL param_range: SETUP/HOLD outside 1..255");
         $fatal(1);
      end
   end

   // Issue one request on the selected instance and measure it relative to the accept edge.
   task automatic run_op(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input bit keep, input bit perturb,
                         output int acc_cyc, output int ce_rise, output int ce_len,
                         output int rsp_at, output int rsp_cnt, output int ready_at,
                         output int unstable, output logic [DW-1:0] rdata);
      int n;
      req_we = we; req_addr = addr; req_wdata = data; req_valid = 1'b1;
      acc_cyc = -1; ce_rise = -1; ce_len = 0; rsp_at = -1; rsp_cnt = 0;
      ready_at = -1; unstable = 0; rdata = m_rdata;
      n = 0;
      while (m_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      if (m_ready !== 1'b1) begin req_valid = 1'b0; return; end
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      if (perturb) begin req_addr = 10'h111; req_we = 1'b1; end
      else if (!keep) req_valid = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (m_ce === 1'b1 && ce_rise < 0) ce_rise = k;
         if (m_ce === 1'b1) ce_len++;
         if (m_rsp === 1'b1) begin rsp_cnt++; rsp_at = k; end
         if (m_addr !== addr || m_we !== we || m_data !== data) unstable++;
         if (m_ready === 1'b1) begin ready_at = k; break; end
      end
      rdata = m_rdata;
      if (!keep) req_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      compared++;
      if ({req_ready0, busy0, rsp_valid0, mem_we0, mem_ce0, rsp_rdata0, mem_address0, mem_data0} !== '0) begin
         mismatched++;
         $display("FAIL reset_outputs: got ready=%b busy=%b rsp=%b we=%b ce=%b rdata=%h addr=%h data=%h required all zero",
                  req_ready0, busy0, rsp_valid0, mem_we0, mem_ce0, rsp_rdata0, mem_address0, mem_data0);
      end
      rst_n = 1'b1;
      #1;
      compared++;
      if (req_ready0 !== 1'b0) begin mismatched++; $display("FAIL ready_before_edge: got %b required 0", req_ready0); end
      @(negedge clk);
      compared++;
      if (req_ready0 !== 1'b1) begin mismatched++; $display("FAIL ready_after_edge: got %b required 1", req_ready0); end
      compared++;
      if (busy0 !== 1'b0) begin mismatched++; $display("FAIL busy_idle: got %b required 0", busy0); end
      repeat (10) @(negedge clk);
      compared++;
      if (ce_edges0 !== 0) begin mismatched++; $display("FAIL idle_no_ce: got %0d CE rises required 0", ce_edges0); end
      compared++;
      if ({mem_address0, mem_data0, rsp_rdata0} !== '0) begin
         mismatched++; $display("FAIL idle_outputs: got addr=%h data=%h rdata=%h required 0", mem_address0, mem_data0, rsp_rdata0);
      end
      $display("reset: ready=%b busy=%b ce_rises=%0d", req_ready0, busy0, ce_edges0);
   endtask

   task automatic test_write_read();
      int a, r, l, ra, rc, rd, u;
      logic [DW-1:0] pre, got;
      pre = rsp_rdata0;
      run_op(1'b1, 10'h005, 18'h2ABCD, 1'b0, 1'b0, a, r, l, ra, rc, rd, u, got);
      ref_mem[10'h005] = 18'h2ABCD;
      $display("write addr=005 data=2abcd ce_rise=%0d ce_len=%0d rsp=%0d ready=%0d", r, l, rc, rd);
      compared++; if (l !== H0) begin mismatched++; $display("FAIL wr_ce_len: got %0d required %0d", l, H0); end
      compared++; if (rc !== 0) begin mismatched++; $display("FAIL wr_no_rsp: got %0d pulses required 0", rc); end
      compared++; if (got !== pre) begin mismatched++; $display("FAIL wr_rdata_hold: got %h required %h", got, pre); end
      compared++; if (rd !== S0 + H0 + 1) begin mismatched++; $display("FAIL wr_ready_at: got %0d required %0d", rd, S0 + H0 + 1); end
      run_op(1'b0, 10'h005, 18'h0, 1'b0, 1'b0, a, r, l, ra, rc, rd, u, got);
      $display("read addr=005 rdata=%h rsp_at=%0d ce_len=%0d", got, ra, l);
      compared++; if (l !== H0) begin mismatched++; $display("FAIL rd_ce_len: got %0d required %0d", l, H0); end
      compared++; if (rc !== 1) begin mismatched++; $display("FAIL rd_rsp_cnt: got %0d required 1", rc); end
      compared++; if (ra !== S0 + H0) begin mismatched++; $display("FAIL rd_rsp_at: got %0d required %0d", ra, S0 + H0); end
      compared++; if (got !== ref_mem[10'h005]) begin mismatched++; $display("FAIL rd_data: got %h required %h", got, ref_mem[10'h005]); end
      compared++; if (u !== 0) begin mismatched++; $display("FAIL rd_pins_stable: got %0d unstable samples required 0", u); end
   endtask

   task automatic test_back_to_back();
      int a, r, l, ra, rc, rd, u, prev_acc, viol0;
      logic [DW-1:0] got;
      viol0 = chg_viol;
      prev_acc = -1;
      for (int i = 0; i < 8; i++) begin
         logic [AW-1:0] ad;
         logic wr;
         ad = AW'(i % 4);
         wr = (i < 4);
         run_op(wr, ad, 18'(ad) + 18'h100, (i != 7), 1'b0, a, r, l, ra, rc, rd, u, got);
         if (wr) ref_mem[ad] = 18'(ad) + 18'h100;
         $display("b2b op=%0d we=%b addr=%h acc=%0d rdata=%h", i, wr, ad, a, got);
         if (i > 0) begin
            compared++;
            if (a - prev_acc !== S0 + H0 + 2) begin mismatched++; $display("FAIL b2b_period: got %0d required %0d", a - prev_acc, S0 + H0 + 2); end
         end
         if (!wr) begin
            compared++;
            if (got !== ref_mem[ad] || rc !== 1) begin mismatched++; $display("FAIL b2b_rdata: got %h (%0d pulses) required %h", got, rc, ref_mem[ad]); end
         end
         prev_acc = a;
      end
      @(negedge clk);
      compared++;
      if (chg_viol !== viol0) begin mismatched++; $display("FAIL b2b_pin_change: got %0d changes while CE high required 0", chg_viol - viol0); end
   endtask

   task automatic test_stretched();
      int a, r, l, ra, rc, rd, u, a1;
      logic [DW-1:0] got;
      ram1[10'h3FF] = 18'h3FFFF;
      @(negedge clk);
      sel = 1'b1;
      run_op(1'b0, 10'h3FF, 18'h0, 1'b1, 1'b0, a1, r, l, ra, rc, rd, u, got);
      $display("stretch read addr=3ff rdata=%h ce_rise=%0d ce_len=%0d rsp_at=%0d", got, r, l, ra);
      compared++; if (r !== S1) begin mismatched++; $display("FAIL st_ce_rise: got %0d required %0d", r, S1); end
      compared++; if (l !== H1) begin mismatched++; $display("FAIL st_ce_len: got %0d required %0d", l, H1); end
      compared++; if (ra !== S1 + H1) begin mismatched++; $display("FAIL st_rsp_at: got %0d required %0d", ra, S1 + H1); end
      compared++; if (got !== 18'h3FFFF) begin mismatched++; $display("FAIL st_rdata: got %h required 3ffff", got); end
      run_op(1'b0, 10'h3FF, 18'h0, 1'b0, 1'b0, a, r, l, ra, rc, rd, u, got);
      $display("stretch read addr=3ff rdata=%h period=%0d", got, a - a1);
      compared++; if (a - a1 !== S1 + H1 + 2) begin mismatched++; $display("FAIL st_period: got %0d required %0d", a - a1, S1 + H1 + 2); end
      compared++; if (rc !== 1) begin mismatched++; $display("FAIL st_rsp_cnt: got %0d required 1", rc); end
      sel = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_busy_isolation();
      int a, r, l, ra, rc, rd, u, e0;
      logic [DW-1:0] got;
      e0 = ce_edges0;
      run_op(1'b0, 10'h005, 18'h0, 1'b0, 1'b1, a, r, l, ra, rc, rd, u, got);
      $display("isolation read addr=005 rdata=%h unstable=%0d ce_rises=%0d", got, u, ce_edges0 - e0);
      compared++; if (u !== 0) begin mismatched++; $display("FAIL iso_pins: got %0d unstable samples required 0", u); end
      compared++; if (ce_edges0 - e0 !== 1) begin mismatched++; $display("FAIL iso_ce_pulses: got %0d required 1", ce_edges0 - e0); end
      compared++; if (got !== ref_mem[10'h005]) begin mismatched++; $display("FAIL iso_rdata: got %h required %h", got, ref_mem[10'h005]); end
   endtask

   task automatic test_random();
      int a, r, l, ra, rc, rd, u;
      logic [DW-1:0] got, pre, wd;
      logic [AW-1:0] ad;
      logic wr;
      for (int i = 0; i < 30; i++) begin
         ad = 10'h200 + AW'($urandom_range(0, 7));
         wr = 1'($urandom_range(0, 1));
         wd = 18'($urandom);
         pre = rsp_rdata0;
         run_op(wr, ad, wd, (i != 29) && ($urandom_range(0, 1) == 1), 1'b0, a, r, l, ra, rc, rd, u, got);
         $display("rand op=%0d we=%b addr=%h wdata=%h rdata=%h rsp=%0d", i, wr, ad, wd, got, rc);
         compared++;
         if (r !== S0 || l !== H0 || rd !== S0 + H0 + 1 || u !== 0) begin
            mismatched++;
            $display("FAIL rand_timing: got rise=%0d len=%0d ready=%0d unstable=%0d required %0d %0d %0d 0", r, l, rd, u, S0, H0, S0 + H0 + 1);
         end
         compared++;
         if (wr) begin
            ref_mem[ad] = wd;
            if (rc !== 0 || got !== pre) begin mismatched++; $display("FAIL rand_write_rsp: got %0d pulses rdata=%h required 0 pulses rdata=%h", rc, got, pre); end
         end else begin
            if (rc !== 1 || ra !== S0 + H0 || got !== ref_mem[ad]) begin
               mismatched++; $display("FAIL rand_read: got %h (%0d pulses at %0d) required %h", got, rc, ra, ref_mem[ad]);
            end
         end
      end
   endtask

   task automatic test_reset_midop();
      int n, p0, a, r, l, ra, rc, rd, u;
      logic [DW-1:0] got;
      @(negedge clk);
      req_we = 1'b0; req_addr = 10'h201; req_valid = 1'b1;
      n = 0;
      while (req_ready0 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (S0 + 1) @(negedge clk);
      compared++;
      if (mem_ce0 !== 1'b1) begin mismatched++; $display("FAIL mid_in_strobe: got ce=%b required 1", mem_ce0); end
      p0 = rsp_pulses0;
      #3 rst_n = 1'b0;
      #1;
      compared++;
      if (mem_ce0 !== 1'b0 || rsp_valid0 !== 1'b0 || busy0 !== 1'b0) begin
         mismatched++; $display("FAIL mid_async_clear: got ce=%b rsp=%b busy=%b required 0 0 0", mem_ce0, rsp_valid0, busy0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      compared++;
      if (rsp_pulses0 !== p0) begin mismatched++; $display("FAIL mid_no_rsp: got %0d pulses required 0", rsp_pulses0 - p0); end
      $display("reset mid-op: ce=%b rsp_pulses=%0d", mem_ce0, rsp_pulses0 - p0);
      run_op(1'b0, 10'h201, 18'h0, 1'b0, 1'b0, a, r, l, ra, rc, rd, u, got);
      $display("post-reset read addr=201 rdata=%h", got);
      compared++;
      if (got !== ref_mem[10'h201] || rc !== 1) begin mismatched++; $display("FAIL mid_resume: got %h (%0d pulses) required %h", got, rc, ref_mem[10'h201]); end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin ram0[i] = '0; ram1[i] = '0; ref_mem[i] = '0; end
      mem_q0 = '0;
      mem_q1 = '0;
      test_reset();
      test_write_read();
      test_back_to_back();
      test_stretched();
      test_busy_isolation();
      test_random();
      test_reset_midop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete, required completion");
      $fatal(1);
   end
endmodule

// File: doc/ram_initiator.md
Name: ram_initiator

Overview:
- Bus-side initiator that drives the team's CE-strobed 1Kx18 RAM. The RAM acts on the rising edge of CE: it writes when WE is high and loads q when WE is low.
- Accepts single read/write requests from the processor datapath over a valid/ready handshake.
- Sequences address, data and WE setup, then the CE pulse, and captures q for reads.
- Sits between the processor load/store stage and the RAM instance, and guarantees clean, clock-aligned CE edges.

Parameters:
- ADDR_W, 10, RAM address width.
- DATA_W, 18, RAM data width.
- SETUP_CYC, 1, clocks that address/data/WE are stable with CE low before the CE rise. Legal range 1..255.
- HOLD_CYC, 1, clocks that CE stays high. Legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  initiator can accept; high only in IDLE.
- req_we  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle pulse; rsp_rdata is valid (reads only).
- rsp_rdata  out  DATA_W  read data; holds until the next read completes.
- busy  out  1  high in any state other than IDLE.
- mem_address  out  ADDR_W  to RAM address.
- mem_data  out  DATA_W  to RAM data.
- mem_we  out  1  to RAM WE.
- mem_ce  out  1  to RAM CE.
- mem_q  in  DATA_W  from RAM q.

Behaviour:
- Reset (async, rst_n low), all outputs are:
  - req_ready=0, busy=0, rsp_valid=0, rsp_rdata=0.
  - mem_address=0, mem_data=0, mem_we=0, mem_ce=0.
  - State is IDLE and the 8-bit counter is 0.
- First clock edge after rst_n rises: req_ready goes to 1.
- All outputs are registered; mem_ce comes directly from a flop, never from combinational logic.
- States:
  - IDLE: req_ready=1, mem_ce=0. On req_valid&req_ready at edge E, register addr/wdata/we onto mem_*, load counter=SETUP_CYC-1, go to SETUP.
  - SETUP: mem_ce=0, mem_* stable. When counter==0, set mem_ce=1, load counter=HOLD_CYC-1, go to STROBE. Otherwise decrement.
  - STROBE: mem_ce=1, mem_* stable. When counter==0, set mem_ce=0 and go to RECOVER. On a read, also sample mem_q into rsp_rdata and pulse rsp_valid. Otherwise decrement.
  - RECOVER: mem_ce=0, rsp_valid=0, mem_* still held. The next edge goes to IDLE.
- Timing with defaults:
  - Accept at edge E; CE rises after E+1; CE falls and rsp_valid asserts after E+2; IDLE after E+3.
  - Earliest next accept is at E+4.
  - General period is SETUP_CYC+HOLD_CYC+2 clocks.
  - Read sampling happens ≥1 clock after the CE rise, so the RAM's q update has settled.
- mem_address, mem_data and mem_we never change while mem_ce=1 or in the cycle CE falls. They change only on the accept edge.
- Writes: rsp_valid is never asserted and rsp_rdata is unchanged.
- Input isolation: req_* is ignored outside IDLE. Request inputs may change freely while busy=1.
- Reset mid-operation: CE is forced low (a falling edge, so no RAM action) and no rsp_valid is issued. An in-flight write may or may not have completed, depending on whether CE had already risen.
- Bounds: counters are 8 bits. SETUP_CYC or HOLD_CYC of 0 is illegal; the bench checks the parameter range at elaboration.

Test Plan:
- Reset then idle: rst_n=0 for 3 clocks, then release -> all mem_* =0, rsp_rdata=0; req_ready=1 one edge after release; mem_ce never toggles without a request.
- Write then read, defaults: write addr=0x005, data=0x2ABCD, then read addr=0x005 -> mem_ce is high for exactly 1 clock per op; rsp_valid pulses once, 2 edges after the read accept; rsp_rdata=0x2ABCD.
- Back-to-back requests: req_valid held high with writes to 0x000..0x003, data=addr+0x100, then reads of the same addresses -> accepts every 4 clocks; reads return 0x100..0x103 in order; WE/address are never observed changing while mem_ce=1.
- Stretched timing, SETUP_CYC=3, HOLD_CYC=2: read of 0x3FF preloaded with 0x3FFFF -> CE rises 3 clocks after accept and stays high for 2; rsp_rdata=0x3FFFF; period is 7 clocks.
- Busy isolation: during SETUP, toggle req_addr=0x111 and req_we=1 -> mem_address and mem_we keep their accepted values; only one CE pulse occurs.
- Reset mid-op: assert rst_n low while in STROBE of a read -> mem_ce=0 immediately with no clock edge needed; no rsp_valid; after release, normal operation resumes with a fresh read returning correct data.
